// File: rtl/sdram_image_writer_if.sv
// Bus bundle for sdram_image_writer: the pixel FIFO read port and the
// Avalon-MM write master toward the SDRAM controller.
interface sdram_image_writer_if #(
  parameter int ADDR_WIDTH = 25
);
  logic                  oRDFIFO_REQ;
  logic [7:0]            iRDFIFO_DATA;
  logic                  iRDFIFO_EMPTY;
  logic                  oSDRAM_WRITE;
  logic [ADDR_WIDTH-1:0] oSDRAM_ADDR;
  logic [15:0]           oSDRAM_WRDATA;
  logic                  iSDRAM_WAIT;

  // The writer drives requests and writes; FIFO and SDRAM answer.
  modport master (
    output oRDFIFO_REQ, oSDRAM_WRITE, oSDRAM_ADDR, oSDRAM_WRDATA,
    input  iRDFIFO_DATA, iRDFIFO_EMPTY, iSDRAM_WAIT
  );

  modport slave (
    input  oRDFIFO_REQ, oSDRAM_WRITE, oSDRAM_ADDR, oSDRAM_WRDATA,
    output iRDFIFO_DATA, iRDFIFO_EMPTY, iSDRAM_WAIT
  );
endinterface

// File: rtl/sdram_image_writer.sv
// sdram_image_writer: drains the decoded-pixel FIFO, packs byte pairs into
// 16-bit words (first byte = low byte) and writes N frames to SDRAM word
// addresses starting at 0 through an Avalon-MM write master.
// Optional feature: define SDRAM_IMAGE_WRITER_CHECKSUM_EN to add oCHECKSUM,
// a mod-2^16 sum of every accepted word.
module sdram_image_writer #(
  parameter int FRAME_BYTES_LOG2 = 20,
  parameter int ADDR_WIDTH       = 25,
  parameter int CNT_WIDTH        = 26
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iTRIGGER,
  input  logic [6:0]           iNUM_IMAGES,
  sdram_image_writer_if.master bus,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic [6:0]           oFRAME_INDEX
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]          oCHECKSUM
`endif
);

  typedef enum logic [2:0] {
    IDLE, CHECK, RD_LO, CAP_LO, RD_HI, CAP_HI, WRITE, FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            sync_q;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           word_q, word_d;
  logic                  rdReq;
  logic                  startEvt;
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
  logic [15:0]           chk_q, chk_d;
`endif

  // The trigger comes from the decoder clock; a rising edge seen between
  // the second and third synchronizer flops starts a transfer.
  assign startEvt = sync_q[1] & ~sync_q[2];

  // Synchronizer, state and datapath registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q  <= '0;
      state_q <= IDLE;
      total_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      sync_q  <= {sync_q[1:0], iTRIGGER};
      state_q <= state_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Next-state and datapath updates; a FIFO read is requested only when
  // data is available, and the following state captures the byte.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    rdReq   = 1'b0;
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (startEvt) begin
          total_d = CNT_WIDTH'(iNUM_IMAGES) << (FRAME_BYTES_LOG2 - 1);
          cnt_d   = '0;
          addr_d  = '0;
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
          chk_d   = '0;
`endif
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = (cnt_q == total_q) ? FINISH : RD_LO;
      end
      RD_LO: begin
        if (!bus.iRDFIFO_EMPTY) begin
          rdReq   = 1'b1;
          state_d = CAP_LO;
        end
      end
      CAP_LO: begin
        word_d[7:0] = bus.iRDFIFO_DATA;
        state_d     = RD_HI;
      end
      RD_HI: begin
        if (!bus.iRDFIFO_EMPTY) begin
          rdReq   = 1'b1;
          state_d = CAP_HI;
        end
      end
      CAP_HI: begin
        word_d[15:8] = bus.iRDFIFO_DATA;
        state_d      = WRITE;
      end
      WRITE: begin
        if (!bus.iSDRAM_WAIT) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
          chk_d   = chk_q + word_q;
`endif
          state_d = CHECK;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign bus.oRDFIFO_REQ   = rdReq;
  assign bus.oSDRAM_WRITE  = (state_q == WRITE);
  assign bus.oSDRAM_ADDR   = addr_q;
  assign bus.oSDRAM_WRDATA = word_q;
  assign oBUSY             = (state_q != IDLE);
  assign oDONE             = (state_q == FINISH);
  assign oFRAME_INDEX      = 7'(cnt_q >> (FRAME_BYTES_LOG2 - 1));
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
  assign oCHECKSUM         = chk_q;
`endif

endmodule

// File: tb/tb_sdram_image_writer.sv
// Testbench for sdram_image_writer with small frames (16 bytes, 8 words).
// A FIFO model and an SDRAM responder surround the DUT; expected writes are
// queued when a transfer is issued and popped by the monitor on acceptance.
module tb_sdram_image_writer;

  localparam int FBL = 4;
  localparam int WPF = 1 << (FBL - 1);
  localparam int AW  = 25;
  localparam int CW  = 26;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [6:0] nimgIn = 7'd0;
  logic       busy;
  logic       done;
  logic [6:0] frameIdx;
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  sdram_image_writer_if #(.ADDR_WIDTH(AW)) bus ();

  sdram_image_writer #(
    .FRAME_BYTES_LOG2(FBL),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .iTRIGGER(trig),
    .iNUM_IMAGES(nimgIn),
    .bus(bus),
    .oBUSY(busy),
    .oDONE(done),
    .oFRAME_INDEX(frameIdx)
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
    ,
    .oCHECKSUM(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned frame;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] fifoQ[$];
  int  nChecks = 0;
  int  nFail = 0;
  int  acceptCount = 0;
  int  doneCount = 0;
  int  holdCount = 0;
  int  popCount = 0;
  int  popSeq = 0;
  int  lastSeq = 0;
  logic [7:0] popByte = 8'd0;
  bit  randWait = 0;
  bit  randStall = 0;
  bit  forceWait = 0;
  bit  stallOn = 0;
  int  waitAddr = -1;
  int  waitLeft = 0;
  int  stallAt = -1;
  int  stallLeft = 0;
  bit  prevReq = 0;
  bit  heldPrev = 0;
  logic [31:0] prevAddr = 0;
  logic [15:0] prevData = 0;
  logic [15:0] modelSum = 16'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // FIFO q updates on the clock edge that follows a request.
  always @(posedge clk) begin
    if (popSeq != lastSeq) begin
      bus.iRDFIFO_DATA = popByte;
      lastSeq = popSeq;
    end
  end

  // Drive the SDRAM wait and FIFO empty inputs, then monitor the DUT outputs.
  always @(negedge clk) begin
    if (forceWait)
      bus.iSDRAM_WAIT = 1'b1;
    else if (bus.oSDRAM_WRITE && waitLeft > 0 && int'(bus.oSDRAM_ADDR) == waitAddr) begin
      bus.iSDRAM_WAIT = 1'b1;
      waitLeft--;
    end else if (randWait)
      bus.iSDRAM_WAIT = ($urandom_range(0, 2) == 0);
    else
      bus.iSDRAM_WAIT = 1'b0;

    if (stallAt >= 0 && popCount == stallAt) begin
      stallLeft = 10;
      stallAt = -1;
    end
    stallOn = 1'b0;
    if (stallLeft > 0) begin
      stallLeft--;
      stallOn = 1'b1;
    end
    if (randStall && $urandom_range(0, 4) == 0) stallOn = 1'b1;
    bus.iRDFIFO_EMPTY = (fifoQ.size() == 0) || stallOn;

    #1;
    if (rst_n) begin
      if (bus.oRDFIFO_REQ) begin
        checkOutput("req_while_empty", {31'd0, bus.iRDFIFO_EMPTY}, 32'd0);
        checkOutput("req_back_to_back", {31'd0, prevReq}, 32'd0);
        checkOutput("req_during_write", {31'd0, bus.oSDRAM_WRITE}, 32'd0);
        if (fifoQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL fifo_underflow: read request with model FIFO empty");
        end else begin
          popByte = fifoQ.pop_front();
          popSeq++;
          popCount++;
        end
      end
      prevReq = bus.oRDFIFO_REQ;

      if (heldPrev) begin
        checkOutput("hold_write", {31'd0, bus.oSDRAM_WRITE}, 32'd1);
        checkOutput("hold_addr", 32'(bus.oSDRAM_ADDR), prevAddr);
        checkOutput("hold_data", {16'd0, bus.oSDRAM_WRDATA}, {16'd0, prevData});
      end
      heldPrev = bus.oSDRAM_WRITE && bus.iSDRAM_WAIT;
      prevAddr = 32'(bus.oSDRAM_ADDR);
      prevData = bus.oSDRAM_WRDATA;

      if (bus.oSDRAM_WRITE && int'(bus.oSDRAM_ADDR) == 2) holdCount++;

      if (bus.oSDRAM_WRITE && !bus.iSDRAM_WAIT) begin
        acceptCount++;
        if (expQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                   bus.oSDRAM_ADDR, bus.oSDRAM_WRDATA);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("wr_addr", 32'(bus.oSDRAM_ADDR), e.addr);
          checkOutput("wr_data", {16'd0, bus.oSDRAM_WRDATA}, e.data);
          checkOutput("frame_index", {25'd0, frameIdx}, e.frame);
        end
      end
      if (done) doneCount++;
    end else begin
      prevReq = 1'b0;
      heldPrev = 1'b0;
    end
  end

  task automatic pulseTrigger();
    @(negedge clk);
    #3 trig = 1'b1;
    @(negedge clk);
    #3 trig = 1'b0;
  endtask

  // Issue one transfer: fill the FIFO model, queue the expected words,
  // trigger, wait for completion and check the end-of-transfer state.
  task automatic applyStimulus(input int nimg, input bit ramp, input bit retrig);
    logic [7:0] b[];
    int startAccept;
    int startDone;
    int cyc;
    b = new[nimg * WPF * 2];
    for (int k = 0; k < nimg * WPF * 2; k++) begin
      b[k] = ramp ? 8'(k) : 8'($urandom_range(0, 255));
      fifoQ.push_back(b[k]);
    end
    modelSum = 16'd0;
    for (int w = 0; w < nimg * WPF; w++) begin
      exp_t e;
      e.addr  = w;
      e.data  = {16'd0, b[2*w+1], b[2*w]};
      e.frame = w / WPF;
      expQ.push_back(e);
      modelSum = modelSum + 16'(e.data);
    end
    nimgIn = 7'(nimg);
    startAccept = acceptCount;
    startDone = doneCount;
    pulseTrigger();
    cyc = 0;
    while (doneCount == startDone && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (retrig && cyc == 10) pulseTrigger();
    end
    if (doneCount == startDone)
      $display("[TB] FAIL transfer_timeout: no done after %0d cycles", cyc);
    repeat (20) @(negedge clk);
    #2;
    checkOutput("done_pulses", 32'(doneCount - startDone), 32'd1);
    checkOutput("write_count", 32'(acceptCount - startAccept), 32'(nimg * WPF));
    checkOutput("exp_left", 32'(expQ.size()), 32'd0);
    checkOutput("busy_after", {31'd0, busy}, 32'd0);
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
    checkOutput("checksum", {16'd0, checksum}, {16'd0, modelSum});
`endif
    expQ.delete();
    fifoQ.delete();
  endtask

  initial begin
    int cyc;
    int startDone;
    int startAccept;
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_frame", {25'd0, frameIdx}, 32'd0);
    checkOutput("rst_req", {31'd0, bus.oRDFIFO_REQ}, 32'd0);
    checkOutput("rst_write", {31'd0, bus.oSDRAM_WRITE}, 32'd0);
    checkOutput("rst_addr", 32'(bus.oSDRAM_ADDR), 32'd0);
    checkOutput("rst_wrdata", {16'd0, bus.oSDRAM_WRDATA}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single frame, ramp data, no waits");
    applyStimulus(1, 1'b1, 1'b0);
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
    checkOutput("checksum_ramp", {16'd0, checksum}, 32'h4038);
`endif

    $display("[TB] backpressure on word 2");
    holdCount = 0;
    waitAddr = 2;
    waitLeft = 3;
    applyStimulus(1, 1'b1, 1'b0);
    checkOutput("stall_hold_cycles", 32'(holdCount), 32'd4);
    waitAddr = -1;

    $display("[TB] FIFO empty for 10 cycles after byte 5");
    popCount = 0;
    stallAt = 6;
    applyStimulus(1, 1'b1, 1'b0);

    $display("[TB] three frames");
    applyStimulus(3, 1'b1, 1'b0);

    $display("[TB] zero frames");
    nimgIn = 7'd0;
    startDone = doneCount;
    startAccept = acceptCount;
    pulseTrigger();
    cyc = 0;
    while (doneCount == startDone && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("zero_done_latency_ok", {31'd0, (cyc <= 8)}, 32'd1);
    checkOutput("zero_writes", 32'(acceptCount - startAccept), 32'd0);

    $display("[TB] retrigger mid-transfer");
    applyStimulus(1, 1'b0, 1'b1);

    $display("[TB] randomized waits and stalls");
    randWait = 1;
    randStall = 1;
    for (int r = 0; r < 3; r++) applyStimulus($urandom_range(1, 3), 1'b0, 1'b0);
    randWait = 0;
    randStall = 0;

    $display("[TB] reset during write");
    forceWait = 1;
    nimgIn = 7'd1;
    for (int k = 0; k < 2 * WPF; k++) fifoQ.push_back(8'(k + 16));
    pulseTrigger();
    cyc = 0;
    while (!bus.oSDRAM_WRITE && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("write_reached", {31'd0, bus.oSDRAM_WRITE}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_write", {31'd0, bus.oSDRAM_WRITE}, 32'd0);
    checkOutput("arst_addr", 32'(bus.oSDRAM_ADDR), 32'd0);
    checkOutput("arst_wrdata", {16'd0, bus.oSDRAM_WRDATA}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_req", {31'd0, bus.oRDFIFO_REQ}, 32'd0);
`ifdef SDRAM_IMAGE_WRITER_CHECKSUM_EN
    checkOutput("arst_checksum", {16'd0, checksum}, 32'd0);
`endif
    forceWait = 0;
    fifoQ.delete();
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    checkOutput("idle_after_reset", {31'd0, busy}, 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
